// File: rtl/ddr_tg_pkg.sv
// Shared definitions for the DDR4 test generator command path:
// arbiter state encoding, requester side ids and beat geometry.
package ddr_tg_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    localparam int BEAT_BYTES = 64;
    localparam logic [3:0] RUN_MAX = 4'hF;

    function automatic logic [3:0] run_inc(input logic [3:0] run);
        return (run == RUN_MAX) ? run : run + 4'd1;
    endfunction

endpackage

// File: rtl/ddr_credit_counter.sv
// Outstanding-command counter: +1 per issued command, -1 per completion,
// with a sticky flag for a completion that arrives while nothing is outstanding.
module ddr_credit_counter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       full,
    output logic       err_underflow
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    assign full = (count >= MAX_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= 4'd0;
            err_underflow <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            if (inc && !dec) begin
                if (count != MAX_CNT) count <= count + 4'd1;
            end else if (dec && !inc) begin
                if (count == 4'd0) err_underflow <= 1'b1;
                else               count         <= count - 4'd1;
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Weighted round-robin arbiter sharing one DDR command port between the write
// and read requesters, with a credit limit on commands in flight.
module ddr_cmd_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WR_WEIGHT       = 1,
    parameter int RD_WEIGHT       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_burst_length,
    output logic              wr_finish,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_burst_length,
    output logic              rd_finish,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rnw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              cpl_valid,
    output logic [3:0]        outstanding,
    output logic              err_cpl_underflow
);

    import ddr_tg_pkg::*;

    localparam logic [3:0] WR_W = 4'(WR_WEIGHT);
    localparam logic [3:0] RD_W = 4'(RD_WEIGHT);

    state_t      state;
    side_t       last_side;
    logic [3:0]  run_cnt;
    logic        credit_full;
    logic        handshake;
    logic        want;
    side_t       pick;
    logic [7:0]  pick_len;

    assign handshake = cmd_valid && cmd_ready;

    ddr_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk           (clk),
        .reset_n       (reset_n),
        .inc           (handshake),
        .dec           (cpl_valid),
        .count         (outstanding),
        .full          (credit_full),
        .err_underflow (err_cpl_underflow)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        want = wr_en || rd_en;
        pick = SIDE_WR;
        if (wr_en && rd_en) begin
            // Hand over once the last side has used up its run.
            if (last_side == SIDE_WR) pick = (run_cnt >= WR_W) ? SIDE_RD : SIDE_WR;
            else                      pick = (run_cnt >= RD_W) ? SIDE_WR : SIDE_RD;
        end else if (rd_en) begin
            pick = SIDE_RD;
        end
        pick_len = (pick == SIDE_RD) ? rd_burst_length : {4'd0, wr_burst_length};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_rnw   <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= 8'd0;
            wr_finish <= 1'b0;
            rd_finish <= 1'b0;
            // Read's run starts exhausted, so the first contention goes to write.
            last_side <= SIDE_RD;
            run_cnt   <= RUN_MAX;
        end else begin
            wr_finish <= 1'b0;
            rd_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (want && !credit_full) begin
                        cmd_rnw   <= (pick == SIDE_RD);
                        cmd_addr  <= (pick == SIDE_RD) ? rd_addr : wr_addr;
                        cmd_len   <= pick_len;
                        cmd_valid <= (pick_len != 8'd0);
                        run_cnt   <= (pick == last_side) ? run_inc(run_cnt) : 4'd1;
                        last_side <= pick;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Zero-length commands are consumed without touching the port.
                    if (cmd_len == 8'd0 || handshake) begin
                        cmd_valid <= 1'b0;
                        wr_finish <= !cmd_rnw;
                        rd_finish <= cmd_rnw;
                        state     <= S_ACK;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed self-checking bench for ddr_cmd_arbiter (MAX_OUTSTANDING 4,
// WR_WEIGHT 3, RD_WEIGHT 1).
module tb_ddr_cmd_arbiter;

    import ddr_tg_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_burst_length;
    logic              wr_finish;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_burst_length;
    logic              rd_finish;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rnw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              cpl_valid;
    logic [3:0]        outstanding;
    logic              err_cpl_underflow;

    logic cpl_manual = 1'b0;
    logic cpl_auto   = 1'b0;
    logic auto_cpl   = 1'b0;

    int   errors = 0;
    int   checks = 0;
    logic hs_log[$];
    int   wr_fin_cnt = 0;
    int   rd_fin_cnt = 0;
    int   valid_cnt  = 0;

    assign cpl_valid = cpl_manual | cpl_auto;

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (4),
        .WR_WEIGHT       (3),
        .RD_WEIGHT       (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_burst_length   (wr_burst_length),
        .wr_finish         (wr_finish),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_burst_length   (rd_burst_length),
        .rd_finish         (rd_finish),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_rnw           (cmd_rnw),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .cpl_valid         (cpl_valid),
        .outstanding       (outstanding),
        .err_cpl_underflow (err_cpl_underflow)
    );

    // Observer: logs handshakes, finish pulses, valid cycles; returns a
    // completion one cycle after each handshake when auto_cpl is set.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) hs_log.push_back(cmd_rnw);
        if (wr_finish) wr_fin_cnt <= wr_fin_cnt + 1;
        if (rd_finish) rd_fin_cnt <= rd_fin_cnt + 1;
        if (cmd_valid) valid_cnt  <= valid_cnt + 1;
        cpl_auto <= auto_cpl && cmd_valid && cmd_ready;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        wr_addr         = '0;
        rd_addr         = '0;
        wr_burst_length = 4'd0;
        rd_burst_length = 8'd0;
        cmd_ready       = 1'b0;
        cpl_manual      = 1'b0;
        auto_cpl        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cmd_valid, cmd_rnw, wr_finish, rd_finish, err_cpl_underflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b rnw=%b wf=%b rf=%b err=%b, want all 0",
                     cmd_valid, cmd_rnw, wr_finish, rd_finish, err_cpl_underflow);
        end
        checks++;
        if (cmd_addr !== 32'h0 || cmd_len !== 8'h0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h len=%h out=%0d, want 0/0/0",
                     cmd_addr, cmd_len, outstanding);
        end
    endtask

    task automatic test_write_only();
        apply_reset();
        wr_en = 1'b1; wr_addr = 32'h0000_1000; wr_burst_length = 4'd8;
        cmd_ready = 1'b1; auto_cpl = 1'b1;
        tick();  // edge N: grant
        checks++;
        if (cmd_valid !== 1'b1 || cmd_rnw !== 1'b0 || cmd_addr !== 32'h1000 || cmd_len !== 8'd8) begin
            errors++;
            $display("FAIL wr_cmd: got valid=%b rnw=%b addr=%h len=%0d, want 1/0/00001000/8",
                     cmd_valid, cmd_rnw, cmd_addr, cmd_len);
        end
        tick();  // edge N+1: handshake
        checks++;
        if (cmd_valid !== 1'b0 || wr_finish !== 1'b1 || rd_finish !== 1'b0 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL wr_finish: got valid=%b wf=%b rf=%b out=%0d, want 0/1/0/1",
                     cmd_valid, wr_finish, rd_finish, outstanding);
        end
        tick();  // edge N+2: back to idle
        checks++;
        if (cmd_valid !== 1'b0 || wr_finish !== 1'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL wr_gap: got valid=%b wf=%b out=%0d, want 0/0/0",
                     cmd_valid, wr_finish, outstanding);
        end
        tick();  // edge N+3: next grant
        wr_en = 1'b0;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h1000) begin
            errors++;
            $display("FAIL wr_next_cmd: got valid=%b addr=%h, want 1/00001000", cmd_valid, cmd_addr);
        end
        repeat (5) tick();
    endtask

    task automatic test_contention();
        int   base_hs;
        int   base_wf;
        int   base_rf;
        int   budget;
        logic exp_seq[8];
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        base_hs = hs_log.size();
        base_wf = wr_fin_cnt;
        base_rf = rd_fin_cnt;
        wr_en = 1'b1; wr_addr = 32'h0000_A000; wr_burst_length = 4'd2;
        rd_en = 1'b1; rd_addr = 32'h0000_B000; rd_burst_length = 8'd4;
        cmd_ready = 1'b1; auto_cpl = 1'b1;
        budget = 0;
        while (hs_log.size() < base_hs + 8 && budget < 60) begin
            tick();
            budget++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (hs_log.size() < base_hs + 8) begin
            errors++;
            $display("FAIL contention_timeout: got %0d grants, want 8 within 60 cycles",
                     hs_log.size() - base_hs);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (hs_log[base_hs + i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL contention_grant%0d: got rnw=%b, want rnw=%b",
                             i, hs_log[base_hs + i], exp_seq[i]);
                end
            end
        end
        repeat (6) tick();
        checks++;
        if (hs_log.size() - base_hs != 8 || wr_fin_cnt - base_wf != 6 || rd_fin_cnt - base_rf != 2) begin
            errors++;
            $display("FAIL contention_finish: got grants=%0d wf=%0d rf=%0d, want 8/6/2",
                     hs_log.size() - base_hs, wr_fin_cnt - base_wf, rd_fin_cnt - base_rf);
        end
    endtask

    task automatic test_credit_limit();
        int base_hs;
        int base_v;
        apply_reset();
        base_hs = hs_log.size();
        rd_en = 1'b1; rd_addr = 32'h0000_2000; rd_burst_length = 8'd4; cmd_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (hs_log.size() - base_hs != 4 || outstanding !== 4'd4 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL credit_full: got cmds=%0d out=%0d valid=%b, want 4/4/0",
                     hs_log.size() - base_hs, outstanding, cmd_valid);
        end
        base_v = valid_cnt;
        repeat (10) tick();
        checks++;
        if (valid_cnt != base_v || outstanding !== 4'd4) begin
            errors++;
            $display("FAIL credit_hold: got valid_cycles=%0d out=%0d, want 0/4",
                     valid_cnt - base_v, outstanding);
        end
        cpl_manual = 1'b1;
        tick();
        cpl_manual = 1'b0;
        repeat (12) tick();
        checks++;
        if (hs_log.size() - base_hs != 5 || outstanding !== 4'd4) begin
            errors++;
            $display("FAIL credit_release: got cmds=%0d out=%0d, want 5/4",
                     hs_log.size() - base_hs, outstanding);
        end
        rd_en = 1'b0;
        cpl_manual = 1'b1;
        repeat (4) tick();
        cpl_manual = 1'b0;
        tick();
        checks++;
        if (outstanding !== 4'd0 || err_cpl_underflow !== 1'b0) begin
            errors++;
            $display("FAIL credit_drain: got out=%0d err=%b, want 0/0", outstanding, err_cpl_underflow);
        end
    endtask

    task automatic test_backpressure();
        int base_hs;
        int base_rf;
        apply_reset();
        base_hs = hs_log.size();
        base_rf = rd_fin_cnt;
        auto_cpl = 1'b1;
        rd_en = 1'b1; rd_addr = 32'h0000_3000; rd_burst_length = 8'h20;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_rnw !== 1'b1 || cmd_addr !== 32'h3000 || cmd_len !== 8'h20) begin
            errors++;
            $display("FAIL bp_cmd: got valid=%b rnw=%b addr=%h len=%h, want 1/1/00003000/20",
                     cmd_valid, cmd_rnw, cmd_addr, cmd_len);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = 32'h0000_4000 + 32'(i * 64);
            rd_burst_length = 8'(i);
            rd_en = i[0];
            tick();
            checks++;
            if (cmd_valid !== 1'b1 || cmd_addr !== 32'h3000 || cmd_len !== 8'h20 || rd_finish !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b addr=%h len=%h rf=%b, want 1/00003000/20/0",
                         i, cmd_valid, cmd_addr, cmd_len, rd_finish);
            end
        end
        rd_en = 1'b0;
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || rd_finish !== 1'b1 || hs_log.size() - base_hs != 1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b rf=%b cmds=%0d, want 0/1/1",
                     cmd_valid, rd_finish, hs_log.size() - base_hs);
        end
        repeat (4) tick();
        checks++;
        if (rd_finish !== 1'b0 || rd_fin_cnt - base_rf != 1 || hs_log.size() - base_hs != 1) begin
            errors++;
            $display("FAIL bp_once: got rf=%b finishes=%0d cmds=%0d, want 0/1/1",
                     rd_finish, rd_fin_cnt - base_rf, hs_log.size() - base_hs);
        end
    endtask

    task automatic test_zero_len_underflow();
        int base_v;
        apply_reset();
        base_v = valid_cnt;
        rd_en = 1'b1; rd_addr = 32'h0000_5000; rd_burst_length = 8'd0; cmd_ready = 1'b1;
        tick();  // granted
        rd_en = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_len !== 8'd0) begin
            errors++;
            $display("FAIL zlen_grant: got valid=%b len=%0d, want 0/0", cmd_valid, cmd_len);
        end
        tick();
        checks++;
        if (rd_finish !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zlen_finish: got rf=%b valid=%b, want 1/0", rd_finish, cmd_valid);
        end
        tick();
        checks++;
        if (rd_finish !== 1'b0 || outstanding !== 4'd0 || valid_cnt != base_v || err_cpl_underflow !== 1'b0) begin
            errors++;
            $display("FAIL zlen_after: got rf=%b out=%0d valid_cycles=%0d err=%b, want 0/0/0/0",
                     rd_finish, outstanding, valid_cnt - base_v, err_cpl_underflow);
        end
        cpl_manual = 1'b1;
        tick();
        cpl_manual = 1'b0;
        checks++;
        if (err_cpl_underflow !== 1'b1 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL underflow: got err=%b out=%0d, want 1/0", err_cpl_underflow, outstanding);
        end
        repeat (3) tick();
        checks++;
        if (err_cpl_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky: got err=%b, want 1", err_cpl_underflow);
        end
    endtask

    task automatic test_reset_mid_handshake();
        int base_wf;
        apply_reset();
        wr_en = 1'b1; wr_addr = 32'h0000_6000; wr_burst_length = 4'd5; cmd_ready = 1'b1;
        tick();  // grant
        tick();  // handshake
        cmd_ready = 1'b0;
        checks++;
        if (outstanding !== 4'd1) begin
            errors++;
            $display("FAIL rmid_out: got out=%0d, want 1", outstanding);
        end
        tick();  // ack
        tick();  // second grant, stalled
        tick();
        base_wf = wr_fin_cnt;
        checks++;
        if (cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pending: got valid=%b, want 1", cmd_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || outstanding !== 4'd0 || dut.state !== S_IDLE || wr_finish !== 1'b0) begin
            errors++;
            $display("FAIL rmid_clear: got valid=%b out=%0d state=%0d wf=%b, want 0/0/0/0",
                     cmd_valid, outstanding, dut.state, wr_finish);
        end
        rd_en = 1'b1; rd_addr = 32'h0000_7000; rd_burst_length = 8'd3;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_rnw !== 1'b0 || cmd_addr !== 32'h6000 || wr_fin_cnt != base_wf) begin
            errors++;
            $display("FAIL rmid_first_grant: got valid=%b rnw=%b addr=%h lost_finishes=%0d, want 1/0/00006000/0",
                     cmd_valid, cmd_rnw, cmd_addr, wr_fin_cnt - base_wf);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_contention();
        test_credit_limit();
        test_backpressure();
        test_zero_len_underflow();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_arbiter.md
# ddr_cmd_arbiter

Shares one DDR command port between the write-traffic requester and the read-traffic requester of the DDR4 test generator. Each requester holds a level request with address and burst length. The arbiter grants one side with weighted round-robin and issues a single command. It returns a one-cycle finish pulse so the requester can advance. It also counts outstanding commands against a credit limit fed by the memory-side completion channel.

## Interface
- ADDR_W, 32, command address width (byte address)
- MAX_OUTSTANDING, 4, max commands issued but not completed (1..15)
- WR_WEIGHT, 1, consecutive write grants allowed while a read is pending (1..15)
- RD_WEIGHT, 1, consecutive read grants allowed while a write is pending (1..15)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- wr_en  in  1  write request level
- wr_addr  in  ADDR_W  write byte address, stable while wr_en high
- wr_burst_length  in  4  write length in 64-byte beats
- wr_finish  out  1  one-cycle pulse: write request consumed
- rd_en  in  1  read request level
- rd_addr  in  ADDR_W  read byte address
- rd_burst_length  in  8  read length in 64-byte beats
- rd_finish  out  1  one-cycle pulse: read request consumed
- cmd_valid  out  1  command valid
- cmd_ready  in  1  command accepted when high with cmd_valid
- cmd_rnw  out  1  1 = read, 0 = write
- cmd_addr  out  ADDR_W  command address
- cmd_len  out  8  beats (write length zero-extended)
- cpl_valid  in  1  one completion per cycle
- outstanding  out  4  current outstanding count
- err_cpl_underflow  out  1  sticky: cpl_valid seen with outstanding == 0

## Operation
- State machine: S_IDLE, S_ISSUE, S_ACK.
- S_IDLE:
  - If outstanding == MAX_OUTSTANDING, stay.
  - Otherwise pick a side:
    - Only one side requesting: grant it.
    - Both requesting: grant the side not last granted once the run counter reaches that side's weight. Otherwise grant the last side.
  - Latch rnw, addr and len into the cmd_* registers, then go to S_ISSUE.
- Run counter: reset to 1 on a side change, incremented on a same-side grant, saturating at 15. Last side after reset = read, so the first contention grant goes to write.
- S_ISSUE:
  - cmd_valid = 1. All cmd_* outputs are held stable until the cmd_valid & cmd_ready handshake.
  - On handshake: outstanding increments, then go to S_ACK.
- Zero-length requests (len == 0): granted normally, but S_ISSUE exits immediately without asserting cmd_valid. Outstanding is unchanged; go to S_ACK.
- S_ACK:
  - The granted side's finish pulses for exactly one cycle, then go to S_IDLE.
  - Requests are never sampled in S_ACK, so the requester has one cycle to update its address and length.
- Outstanding counter:
  - +1 on handshake, −1 on cpl_valid.
  - Both in the same cycle: unchanged.
  - cpl_valid at 0: counter stays 0 and err_cpl_underflow sets. It is cleared only by reset.
- Requests dropping while in S_ISSUE: ignored. A latched command is always issued.

## Timing
- Reset values: cmd_valid 0, cmd_rnw 0, cmd_addr 0, cmd_len 0, wr_finish 0, rd_finish 0, outstanding 0, err_cpl_underflow 0, state S_IDLE.
- Reset assertion clears all outputs immediately, including a pending cmd_valid mid-handshake. The command is lost and no finish pulse is produced.
- Latency: request high in S_IDLE at edge N gives cmd_valid high from N+1.
  - With cmd_ready high, the handshake happens in cycle N+1.
  - Finish is high in cycle N+2.
  - The earliest next grant decision is at edge N+3.
- Peak throughput: one command per 3 cycles.
- Credit check uses the registered outstanding value. A completion in the same cycle as an S_IDLE evaluation frees a credit only from the next cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package ddr_tg_pkg holds:
  - state encoding constants S_IDLE/S_ISSUE/S_ACK
  - SIDE_WR/SIDE_RD constants
  - the beat size constant BEAT_BYTES = 64
- One sub-module, ddr_credit_counter: up/down saturating counter with underflow flag, parameterised by MAX_OUTSTANDING.
- Grant logic and FSM stay in the top module.

## Test plan
- Write only: wr_en held, wr_addr 0x0000_1000, length 8, cmd_ready 1.
  - Expect cmd_valid at N+1 with cmd_rnw 0, cmd_addr 0x1000, cmd_len 8.
  - Expect wr_finish at N+2; next command at N+4.
- Contention, WR_WEIGHT 3 / RD_WEIGHT 1, both held, completions returned promptly (1–2 cycles after each handshake, never underflow):
  - Expect grant sequence W,W,W,R,W,W,W,R.
  - Expect no finish pulse without a matching grant.
- Credit limit, MAX_OUTSTANDING 4, no cpl_valid, rd_en held:
  - Expect exactly 4 commands, then outstanding stays 4 and cmd_valid stays 0.
  - One cpl_valid pulse: expect exactly one more command.
- Backpressure: cmd_ready low for 10 cycles during S_ISSUE while rd_addr and rd_en change.
  - Expect cmd_addr and cmd_len unchanged for all 10 cycles.
  - Expect one handshake, then rd_finish only after it.
- Zero length plus underflow:
  - rd_burst_length 0: expect rd_finish with no cmd_valid and outstanding 0.
  - cpl_valid at outstanding 0: expect err_cpl_underflow = 1 and outstanding 0.
- Reset mid-handshake: assert reset_n low while cmd_valid is high.
  - Expect cmd_valid 0 and outstanding 0 immediately.
  - After release: expect S_IDLE and first contention grant to write.
